// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: reset constants, fetch FSM encoding and the
// IF/ID bundle handed from fetch to decode.
package pipeline_pkg;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;  // addi x0,x0,0

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_KILL
  } fetch_state_e;

  typedef struct packed {
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
  } if_id_t;

  function automatic if_id_t make_if_id(input logic [31:0] instr,
                                        input logic [31:0] pc);
    if_id_t b;
    b.valid = 1'b1;
    b.instr = instr;
    b.pc    = pc;
    b.pc4   = pc + 32'd4;
    return b;
  endfunction

endpackage

// File: rtl/reg_if_id.sv
// IF/ID pipeline register: flush has priority, load captures the next bundle,
// otherwise contents are held (stall).
module reg_if_id #(
  parameter logic [31:0] NOP_INSTR = pipeline_pkg::NOP_INSTR
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush,
  input  logic                load,
  input  pipeline_pkg::if_id_t d,
  output pipeline_pkg::if_id_t q
);

  // NOTE: state is written only with <= inside the async-reset flop so every
  // reader samples the pre-edge value; blocking here would race the readers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= '{valid: 1'b0, instr: NOP_INSTR, pc: 32'h0, pc4: 32'h0};
    end else if (flush) begin
      q.valid <= 1'b0;
      q.instr <= NOP_INSTR;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/estagio_busca.sv
// Instruction-fetch stage: owns the PC, runs the single-outstanding fetch
// handshake, buffers one word during ID stalls and feeds the IF/ID register.
module estagio_busca #(
  parameter logic [31:0] RESET_PC  = pipeline_pkg::RESET_PC,
  parameter logic [31:0] NOP_INSTR = pipeline_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        stall_id,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        if_id_valid,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_pc4
);

  import pipeline_pkg::*;

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  fetch_pc_q, fetch_pc_d;
  if_id_t       hold_q, hold_d;      // hold_q.valid doubles as "buffer full"
  if_id_t       if_id_q, if_id_d;
  logic         accept, deliver, advance;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_REQ;
      pc_q       <= RESET_PC;
      fetch_pc_q <= 32'h0;
      hold_q     <= '{valid: 1'b0, instr: NOP_INSTR, pc: 32'h0, pc4: 32'h0};
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      fetch_pc_q <= fetch_pc_d;
      hold_q     <= hold_d;
    end
  end

  // Next-state logic; a redirect kills whatever response is still owed.
  // NOTE: every always_comb target gets a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_REQ:  if (accept) state_d = redirect ? S_KILL : S_WAIT;
      S_WAIT: if (imem_rvalid) state_d = S_REQ;
              else if (redirect) state_d = S_KILL;
      S_KILL: if (imem_rvalid) state_d = S_REQ;
      default: state_d = S_REQ;
    endcase
  end

  // Output logic; the request is gated by reset so nothing issues while held.
  always_comb begin
    imem_req = reset && (state_q == S_REQ) && !hold_q.valid;
    accept   = imem_req && imem_ready;
    deliver  = (state_q == S_WAIT) && imem_rvalid && !redirect;
  end

  // PC, hold buffer and IF/ID next values
  always_comb begin
    advance    = !if_id_q.valid || !stall_id;
    pc_d       = pc_q;
    fetch_pc_d = fetch_pc_q;
    hold_d     = hold_q;
    if_id_d    = '{valid: 1'b0, instr: NOP_INSTR, pc: if_id_q.pc, pc4: if_id_q.pc4};

    if (redirect)    pc_d = {redirect_pc[31:2], 2'b00};
    else if (accept) pc_d = pc_q + 32'd4;
    if (accept)      fetch_pc_d = pc_q;

    if (redirect) begin
      hold_d.valid = 1'b0;
    end else if (advance && hold_q.valid) begin
      if_id_d      = hold_q;
      hold_d.valid = 1'b0;
    end else if (deliver && advance) begin
      if_id_d = make_if_id(imem_rdata, fetch_pc_q);
    end else if (deliver) begin
      hold_d = make_if_id(imem_rdata, fetch_pc_q);
    end
  end

  reg_if_id #(.NOP_INSTR(NOP_INSTR)) u_reg_if_id (
    .clk   (clk),
    .reset (reset),
    .flush (redirect),
    .load  (advance),
    .d     (if_id_d),
    .q     (if_id_q)
  );

  assign imem_addr   = pc_q;
  assign if_id_valid = if_id_q.valid;
  assign if_id_instr = if_id_q.instr;
  assign if_id_pc    = if_id_q.pc;
  assign if_id_pc4   = if_id_q.pc4;

endmodule

// File: tb/tb_estagio_busca.sv
// Directed bench for estagio_busca: small memory model answering each accept
// after a programmable latency, with hand-computed expected outputs.
module tb_estagio_busca;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        stall_id;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        if_id_valid;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_pc4;

  int errors = 0;
  int checks = 0;

  estagio_busca dut (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .stall_id    (stall_id),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .if_id_valid (if_id_valid),
    .if_id_instr (if_id_instr),
    .if_id_pc    (if_id_pc),
    .if_id_pc4   (if_id_pc4)
  );

  always #5 clk = ~clk;

  // Memory model: word at address a reads as 32'h1000_0000 | a unless overridden.
  int          lat = 1;
  bit          ovr = 1'b0;
  logic [31:0] ovr_data = 32'hDEAD_BEEF;
  bit          pend = 1'b0;
  int          cnt = 0;
  logic [31:0] paddr = 32'h0;

  always @(negedge clk) begin
    imem_rvalid = 1'b0;
    if (!reset) begin
      pend = 1'b0;
    end else begin
      if (pend) begin
        if (cnt == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata  = ovr ? ovr_data : (32'h1000_0000 | paddr);
          pend        = 1'b0;
        end else begin
          cnt--;
        end
      end
      if (imem_req && imem_ready) begin
        pend  = 1'b1;
        paddr = imem_addr;
        cnt   = lat - 1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_req"},   imem_req,    32'd0);
    check({tag, "_addr"},  imem_addr,   32'h0);
    check({tag, "_valid"}, if_id_valid, 32'd0);
    check({tag, "_instr"}, if_id_instr, 32'h0000_0013);
    check({tag, "_pc"},    if_id_pc,    32'h0);
    check({tag, "_pc4"},   if_id_pc4,   32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset       = 1'b0;
    imem_ready  = 1'b1;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    stall_id    = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;

    // Reset state and first fetch stream 0,4,8
    tick(); tick();
    check_reset_vals("rst");
    #1 reset = 1'b1;
    #1;
    check("rel_req", imem_req, 32'd1);
    check("rel_addr", imem_addr, 32'h0);
    tick();                                    // accept of 0
    check("p1_req", imem_req, 32'd0);
    tick();                                    // delivery of 0
    check("p2_valid", if_id_valid, 32'd1);
    check("p2_pc", if_id_pc, 32'h0);
    check("p2_pc4", if_id_pc4, 32'h4);
    check("p2_instr", if_id_instr, 32'h1000_0000);
    check("p2_addr", imem_addr, 32'h4);
    check("p2_req", imem_req, 32'd1);
    tick();
    check("p3_bubble", if_id_valid, 32'd0);
    tick();
    check("p4_pc", if_id_pc, 32'h4);
    check("p4_pc4", if_id_pc4, 32'h8);
    tick(); tick();
    check("p6_valid", if_id_valid, 32'd1);
    check("p6_pc", if_id_pc, 32'h8);
    check("p6_pc4", if_id_pc4, 32'hC);
    check("p6_addr", imem_addr, 32'hC);

    // Stall 4 cycles: pc=12 lands in the hold buffer, fetch halts
    stall_id = 1'b1;
    tick();
    check("st1_pc", if_id_pc, 32'h8);
    check("st1_valid", if_id_valid, 32'd1);
    tick();
    check("st2_pc", if_id_pc, 32'h8);
    check("st2_req", imem_req, 32'd0);
    tick();
    check("st3_req", imem_req, 32'd0);
    tick();
    check("st4_req", imem_req, 32'd0);
    check("st4_pc", if_id_pc, 32'h8);
    check("st4_instr", if_id_instr, 32'h1000_0008);
    stall_id = 1'b0;
    tick();
    check("unst_pc", if_id_pc, 32'hC);
    check("unst_pc4", if_id_pc4, 32'h10);
    check("unst_instr", if_id_instr, 32'h1000_000C);
    check("unst_req", imem_req, 32'd1);
    check("unst_addr", imem_addr, 32'h10);
    tick();
    check("unst_bubble", if_id_valid, 32'd0);
    tick();
    check("pc16_pc", if_id_pc, 32'h10);
    check("pc16_valid", if_id_valid, 32'd1);

    // Redirect during WAIT; late response must be discarded
    lat = 3;
    ovr = 1'b1;
    tick();
    check("rw_wait_req", imem_req, 32'd0);
    redirect    = 1'b1;
    redirect_pc = 32'h100;
    tick();
    redirect = 1'b0;
    check("rw_valid", if_id_valid, 32'd0);
    check("rw_instr", if_id_instr, 32'h0000_0013);
    check("rw_kill_req", imem_req, 32'd0);
    tick();
    check("rw_kill_req2", imem_req, 32'd0);
    tick();                                    // DEADBEEF arrives here
    check("rw_disc_valid", if_id_valid, 32'd0);
    check("rw_disc_instr", if_id_instr, 32'h0000_0013);
    check("rw_next_req", imem_req, 32'd1);
    check("rw_next_addr", imem_addr, 32'h100);
    lat = 1;
    ovr = 1'b0;

    // Redirect in the same cycle as rvalid, misaligned target
    tick();
    check("rv_wait_req", imem_req, 32'd0);
    redirect    = 1'b1;
    redirect_pc = 32'h103;
    tick();
    redirect = 1'b0;
    check("rv_req", imem_req, 32'd1);
    check("rv_addr", imem_addr, 32'h100);
    check("rv_valid", if_id_valid, 32'd0);
    tick();
    check("rv_wait2", imem_req, 32'd0);
    tick();
    check("rv_dlv_valid", if_id_valid, 32'd1);
    check("rv_dlv_pc", if_id_pc, 32'h100);
    check("rv_dlv_pc4", if_id_pc4, 32'h104);
    check("rv_dlv_instr", if_id_instr, 32'h1000_0100);

    // Asynchronous reset while waiting for a response
    tick();
    check("ar_wait_req", imem_req, 32'd0);
    #1 reset = 1'b0;
    #1;
    check_reset_vals("ar");
    tick();
    #1 reset = 1'b1;
    #1;
    check("ar_rel_req", imem_req, 32'd1);
    check("ar_rel_addr", imem_addr, 32'h0);
    tick(); tick();
    check("ar_dlv_valid", if_id_valid, 32'd1);
    check("ar_dlv_pc", if_id_pc, 32'h0);

    // Redirect cancels a same-cycle accept, then PC wraps past 0xFFFF_FFFC
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect = 1'b0;
    check("wr_kill_req", imem_req, 32'd0);
    check("wr_kill_valid", if_id_valid, 32'd0);
    tick();
    check("wr_req", imem_req, 32'd1);
    check("wr_addr", imem_addr, 32'hFFFF_FFFC);
    check("wr_disc_valid", if_id_valid, 32'd0);
    tick();
    check("wr_next_addr", imem_addr, 32'h0);
    tick();
    check("wr_valid", if_id_valid, 32'd1);
    check("wr_pc", if_id_pc, 32'hFFFF_FFFC);
    check("wr_pc4", if_id_pc4, 32'h0);
    check("wr_instr", if_id_instr, 32'hFFFF_FFFC);
    check("wr_req2", imem_req, 32'd1);
    check("wr_addr2", imem_addr, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
